image_assembler: RTL

- Receives a raster-order 8-bit grayscale pixel stream over a valid/ready handshake.
- Binarizes each pixel against a threshold and writes it into a LENGTH x WIDTH bit image register.
- When a frame is complete, asserts init_out with a stable image, for direct connection to the classifier's init_in/image inputs.
- Sits between the camera/pixel source and the classifier; it is the writer side of the classifier's image interface.

---
 rtl/image_assembler_if.sv | 22 ++
 rtl/image_assembler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/image_assembler_if.sv
// Pixel stream handshake between a raster pixel source and image_assembler.
// The source drives valid/sof/data; the assembler answers with ready.
interface image_assembler_if;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_sof;
    logic [7:0] pix_data;

    modport master (
        output pix_valid,
        output pix_sof,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_sof,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/image_assembler.sv
// image_assembler: binarizes a raster-order 8-bit pixel stream against THRESHOLD
// and builds a LENGTH x WIDTH bit image. When the last pixel lands, init_out rises
// and the image stays frozen until the next start-of-frame beat.
// Optional feature: define ASSEMBLER_POPCOUNT_EN to add the ones_count output.
module image_assembler #(
    parameter int unsigned LENGTH    = 24,
    parameter int unsigned WIDTH     = 24,
    parameter logic [7:0]  THRESHOLD = 8'd128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    image_assembler_if.slave             pix,
    input  logic                         err_clr,
    output logic [LENGTH-1:0][WIDTH-1:0] image,
    output logic                         init_out,
    output logic                         frame_done,
    output logic                         err
`ifdef ASSEMBLER_POPCOUNT_EN
    ,
    output logic [31:0]                  ones_count
`endif
);

    // A single row or column still needs a 1-bit counter.
    localparam int unsigned RowW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [RowW-1:0] RowLast = RowW'(LENGTH - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
    localparam logic [RowW-1:0] RowOne  = RowW'(1);
    localparam logic [ColW-1:0] ColOne  = ColW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    state_e                       state_q;
    logic [RowW-1:0]              row_q;
    logic [ColW-1:0]              col_q;
    logic [LENGTH-1:0][WIDTH-1:0] image_q;
    logic                         init_q;
    logic                         done_q;
    logic                         err_q;
    logic                         ready_q;
`ifdef ASSEMBLER_POPCOUNT_EN
    logic [31:0]                  ones_q;
`endif

    logic            beat;
    logic            pix_bit;
    logic            accept;
    logic            col_wrap;
    logic            at_last;
    logic            restart_err;
    logic [RowW-1:0] wr_row;
    logic [ColW-1:0] wr_col;
    logic [RowW-1:0] nxt_row;
    logic [ColW-1:0] nxt_col;

    // Decode the current beat: where it writes, and where the next pixel goes.
    always_comb begin
        beat    = pix.pix_valid & ready_q;
        pix_bit = (pix.pix_data >= THRESHOLD);
        // sof beats are taken in any state; plain beats only while filling.
        accept  = beat & (pix.pix_sof | (state_q == StFill));
        // An sof always lands at (0,0), even in the middle of a frame.
        wr_row  = pix.pix_sof ? '0 : row_q;
        wr_col  = pix.pix_sof ? '0 : col_q;
        restart_err = beat & pix.pix_sof & (state_q == StFill);

        col_wrap = (wr_col == ColLast);
        at_last  = col_wrap && (wr_row == RowLast);

        nxt_row = wr_row;
        nxt_col = wr_col;
        if (at_last) begin
            nxt_row = '0;
            nxt_col = '0;
        end else if (col_wrap) begin
            nxt_row = wr_row + RowOne;
            nxt_col = '0;
        end else begin
            nxt_col = wr_col + ColOne;
        end
    end

    // Frame FSM with all outputs registered; init_out only changes on the same
    // edge as the state, so it is never high while an image bit is moving.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            image_q <= '0;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
`ifdef ASSEMBLER_POPCOUNT_EN
            ones_q  <= '0;
`endif
        end else begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;

            // A fresh restart error beats a simultaneous clear.
            if (restart_err) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                StIdle, StFill, StDone: begin
                    if (accept) begin
                        image_q[wr_row][wr_col] <= pix_bit;
                        row_q <= nxt_row;
                        col_q <= nxt_col;
`ifdef ASSEMBLER_POPCOUNT_EN
                        if (pix.pix_sof) begin
                            ones_q <= 32'(pix_bit);
                        end else begin
                            ones_q <= ones_q + 32'(pix_bit);
                        end
`endif
                        if (at_last) begin
                            state_q <= StDone;
                            init_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StFill;
                            init_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    init_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pix.pix_ready = ready_q;
    assign image         = image_q;
    assign init_out      = init_q;
    assign frame_done    = done_q;
    assign err           = err_q;
`ifdef ASSEMBLER_POPCOUNT_EN
    assign ones_count    = ones_q;
`endif

endmodule
